// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the issue stage: opcodes, immediate formats,
// FSM state encoding and a small register-usage decoder.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_e;

  typedef struct packed {
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_wr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } dec_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_OP:                 return FMT_R;
      OP_STORE:              return FMT_S;
      OP_BRANCH:             return FMT_B;
      OP_LUI, OP_AUIPC:      return FMT_U;
      OP_JAL:                return FMT_J;
      default:               return FMT_I;
    endcase
  endfunction

  // x0 is never a dependency: it is neither a real source nor a real destination.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] op;
    op         = instr[6:0];
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    d.rd       = instr[11:7];
    d.rs1_used = !(op inside {OP_LUI, OP_AUIPC, OP_JAL}) && (d.rs1 != 5'd0);
    d.rs2_used = (op inside {OP_OP, OP_STORE, OP_BRANCH}) && (d.rs2 != 5'd0);
    d.rd_wr    = !(op inside {OP_STORE, OP_BRANCH}) && (d.rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to BITS.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [31:0]     instr_i,
  output logic [BITS-1:0] imm_o
);

  logic signed [31:0] v;

  always_comb begin
    v = '0;
    case (imm_fmt(instr_i[6:0]))
      FMT_I:   v = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   v = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   v = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
      FMT_U:   v = {instr_i[31:12], 12'b0};
      FMT_J:   v = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
      default: v = '0;
    endcase
  end

  assign imm_o = BITS'(v);

endmodule

// File: rtl/issue_stage.sv
// Single-slot in-order issue stage: register-file read, scoreboard RAW/WAW
// interlock against writeback, and a valid/ready handshake into execute.
module issue_stage
  import riscv_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [BITS-1:0] if_pc,
  output logic [4:0]      rf_ad1,
  output logic [4:0]      rf_ad2,
  input  logic [BITS-1:0] rf_rs1,
  input  logic [BITS-1:0] rf_rs2,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [BITS-1:0] ex_pc,
  output logic [BITS-1:0] ex_rs1,
  output logic [BITS-1:0] ex_rs2,
  output logic [BITS-1:0] ex_imm,
  output logic [31:0]     ex_instr,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush
);

  state_e          state_q;
  logic [31:0]     instr_q;
  logic [BITS-1:0] pc_q;
  logic [31:0]     sb_q, sb_d, sb_eff, clr_mask, set_mask;
  logic [BITS-1:0] imm;
  dec_t            dec;
  logic            in_issue, accept, fire, hazard;

  assign dec      = decode(instr_q);
  assign in_issue = (state_q == S_ISSUE);

  // rst_n gating keeps if_ready low while reset is held even though state is IDLE.
  assign if_ready = rst_n && !flush && ((state_q == S_IDLE) || (in_issue && ex_ready));
  assign accept   = if_valid && if_ready;
  assign ex_valid = in_issue && !flush;
  assign fire     = ex_valid && ex_ready;

  // A same-edge writeback is already visible through the register file, so
  // the bit it clears no longer blocks.
  assign clr_mask = (wb_valid && wb_rd != 5'd0) ? (32'(1) << wb_rd) : '0;
  assign set_mask = (fire && dec.rd_wr) ? (32'(1) << dec.rd) : '0;
  assign sb_eff   = sb_q & ~clr_mask;
  assign sb_d     = (sb_eff | set_mask) & ~32'(1);

  assign hazard = (dec.rs1_used && sb_eff[dec.rs1]) ||
                  (dec.rs2_used && sb_eff[dec.rs2]) ||
                  (dec.rd_wr    && sb_eff[dec.rd]);

  assign rf_ad1 = (state_q == S_IDLE) ? 5'd0 : dec.rs1;
  assign rf_ad2 = (state_q == S_IDLE) ? 5'd0 : dec.rs2;

  imm_gen #(.BITS(BITS)) u_imm (
    .instr_i (instr_q),
    .imm_o   (imm)
  );

  assign ex_pc    = in_issue ? pc_q : '0;
  assign ex_instr = in_issue ? instr_q : '0;
  assign ex_imm   = in_issue ? imm : '0;
  assign ex_rs1   = in_issue ? rf_rs1 : '0;
  assign ex_rs2   = (in_issue && imm_fmt(instr_q[6:0]) inside {FMT_R, FMT_S, FMT_B}) ? rf_rs2 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (accept) begin
      state_q <= S_WAIT;
      instr_q <= if_instr;
      pc_q    <= if_pc;
    end else begin
      case (state_q)
        S_WAIT:  if (!hazard) state_q <= S_ISSUE;
        S_ISSUE: if (ex_ready) state_q <= S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: decode/immediate vector table, directed handshake
// corners, then random traffic against a transaction-level reference model.
module tb_issue_stage;
  import riscv_pkg::*;

  localparam int BITS = 32;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_valid = 1'b0, if_ready;
  logic [31:0] if_instr = '0, if_pc = '0;
  logic [4:0]  rf_ad1, rf_ad2;
  logic [31:0] rf_rs1, rf_rs2;
  logic        ex_valid, ex_ready = 1'b0;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_instr;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;

  int n_chk = 0, n_fail = 0;

  issue_stage #(.BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_ad1(rf_ad1), .rf_ad2(rf_ad2), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_instr(ex_instr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  always #5 clk = ~clk;

  // Register file: registered read, write visible to a same-edge read.
  logic [31:0] rf [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h1000 + 32'(i);
      rf_rs1 <= '0;
      rf_rs2 <= '0;
    end else begin
      if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
      rf_rs1 <= (wb_valid && wb_rd != 5'd0 && wb_rd == rf_ad1) ? wb_data : rf[rf_ad1];
      rf_rs2 <= (wb_valid && wb_rd != 5'd0 && wb_rd == rf_ad2) ? wb_data : rf[rf_ad2];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode straight from the RV32I encoding rules.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    case (w[6:0])
      7'h33:        return 32'h0;
      7'h23:        return (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
      7'h63:        return (32'($signed(w) >>> 31) << 12) | (32'(w[7]) << 11) |
                           (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      7'h37, 7'h17: return w & 32'hFFFF_F000;
      7'h6F:        return (32'($signed(w) >>> 31) << 20) | (32'(w[19:12]) << 12) |
                           (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default:      return 32'($signed(w) >>> 20);
    endcase
  endfunction

  function automatic bit uses_rs1(input logic [31:0] w);
    return !(w[6:0] inside {7'h37, 7'h17, 7'h6F}) && w[19:15] != 0;
  endfunction
  function automatic bit uses_rs2(input logic [31:0] w);
    return (w[6:0] inside {7'h33, 7'h23, 7'h63}) && w[24:20] != 0;
  endfunction
  function automatic bit writes_rd(input logic [31:0] w);
    return !(w[6:0] inside {7'h23, 7'h63}) && w[11:7] != 0;
  endfunction
  function automatic bit blocked(input logic [31:0] w, input logic [31:0] p);
    return (uses_rs1(w) && p[w[19:15]]) || (uses_rs2(w) && p[w[24:20]]) ||
           (writes_rd(w) && p[w[11:7]]);
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  ad1, ad2;
    logic [31:0] rs1, rs2;
  } vec_t;
  vec_t vt [8];

  logic [31:0] q_instr [$];
  logic [31:0] q_pc [$];
  logic [31:0] pend, w, p;
  logic [7:0]  oplist [9];
  bit          exp_vld, fired, acc;
  int          nrd;
  logic [4:0]  cand [8];

  initial begin
    vt[0] = '{32'h00500093, 32'h00000005, 5'd0, 5'd5,  32'h0,    32'h0};    // addi x1,x0,5
    vt[1] = '{32'h00302423, 32'h00000008, 5'd0, 5'd3,  32'h0,    32'h1003}; // sw x3,8(x0)
    vt[2] = '{32'h123452B7, 32'h12345000, 5'd8, 5'd3,  32'h1008, 32'h0};    // lui x5
    vt[3] = '{32'hFFF00093, 32'hFFFFFFFF, 5'd0, 5'd31, 32'h0,    32'h0};    // addi x1,x0,-1
    vt[4] = '{32'hFE000EE3, 32'hFFFFFFFC, 5'd0, 5'd0,  32'h0,    32'h0};    // beq x0,x0,-4
    vt[5] = '{32'h001000EF, 32'h00000800, 5'd0, 5'd1,  32'h0,    32'h0};    // jal x1,2048
    vt[6] = '{32'h00108133, 32'h00000000, 5'd1, 5'd1,  32'h1001, 32'h1001}; // add x2,x1,x1
    vt[7] = '{32'hFF832483, 32'hFFFFFFF8, 5'd6, 5'd24, 32'h1006, 32'h0};    // lw x9,-8(x6)
    oplist = '{8'h37, 8'h17, 8'h6F, 8'h67, 8'h63, 8'h03, 8'h23, 8'h13, 8'h33};

    // Reset state
    if_instr = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_rf_ad", {rf_ad1, rf_ad2}, 0);
    chk("rst_ex_data", ex_pc | ex_rs1 | ex_rs2 | ex_imm | ex_instr, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_if_ready", 32'(if_ready), 1);

    // Decode/immediate table, one instruction at a time, no hazards
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wb_valid = 1'b0; if_valid = 1'b1; if_instr = vt[k].instr;
      if_pc = 32'h400 + 32'(4 * k); ex_ready = 1'b1; #1;
      chk("tbl_if_ready", 32'(if_ready), 1);
      @(negedge clk); if_valid = 1'b0; #1;
      chk("tbl_wait_valid", 32'(ex_valid), 0);
      chk("tbl_ad1", 32'(rf_ad1), 32'(vt[k].ad1));
      chk("tbl_ad2", 32'(rf_ad2), 32'(vt[k].ad2));
      @(negedge clk); #1;
      chk("tbl_ex_valid", 32'(ex_valid), 1);
      chk("tbl_imm", ex_imm, vt[k].imm);
      chk("tbl_rs1", ex_rs1, vt[k].rs1);
      chk("tbl_rs2", ex_rs2, vt[k].rs2);
      chk("tbl_pc", ex_pc, 32'h400 + 32'(4 * k));
      chk("tbl_instr", ex_instr, vt[k].instr);
      @(negedge clk);
      wb_valid = 1'b1; wb_rd = vt[k].instr[11:7]; wb_data = rf[vt[k].instr[11:7]];
    end
    @(negedge clk); wb_valid = 1'b0;

    // ADDI x1 then dependent ADD x2,x1,x1 accepted on the ADDI's issue edge
    @(negedge clk); if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100; ex_ready = 1'b1;
    @(negedge clk); if_valid = 1'b0; #1;
    chk("addi_ad1", 32'(rf_ad1), 0);
    chk("addi_c1_valid", 32'(ex_valid), 0);
    @(negedge clk); #1;
    chk("addi_c2_valid", 32'(ex_valid), 1);
    chk("addi_imm", ex_imm, 5);
    if_valid = 1'b1; if_instr = 32'h00108133; if_pc = 32'h104; #1;
    chk("add_accept", 32'(if_ready), 1);
    @(negedge clk); if_valid = 1'b0; #1;
    chk("sb1_set", 32'(dut.sb_q[1]), 1);
    chk("add_stall0", 32'(ex_valid), 0);
    @(negedge clk); #1; chk("add_stall1", 32'(ex_valid), 0);
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF; #1;
    chk("add_stallN", 32'(ex_valid), 0);
    @(negedge clk); wb_valid = 1'b0; #1;
    chk("add_issue", 32'(ex_valid), 1);
    chk("add_rs1", ex_rs1, 32'hDEAD_BEEF);
    chk("add_rs2", ex_rs2, 32'hDEAD_BEEF);
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd2; wb_data = rf[2];
    @(negedge clk); wb_valid = 1'b0;

    // SW held by execute backpressure, then ADDI x4 issued with same-edge wb x4
    @(negedge clk); if_valid = 1'b1; if_instr = 32'h00302423; if_pc = 32'h200; ex_ready = 1'b0;
    @(negedge clk); if_instr = 32'h00700213; if_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("sw_valid", 32'(ex_valid), 1);
      chk("sw_pc", ex_pc, 32'h200);
      chk("sw_instr", ex_instr, 32'h00302423);
      chk("sw_imm", ex_imm, 8);
      chk("sw_rs2", ex_rs2, rf[3]);
      chk("sw_if_ready", 32'(if_ready), 0);
    end
    @(negedge clk); ex_ready = 1'b1; #1;
    chk("sw_release_ready", 32'(if_ready), 1);
    @(negedge clk); if_valid = 1'b0; #1;
    chk("sw_sb_unchanged", dut.sb_q, 0);
    @(negedge clk); #1;
    chk("addi4_valid", 32'(ex_valid), 1);
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h7;
    @(negedge clk); wb_valid = 1'b0; #1;
    chk("sb4_set_wins", 32'(dut.sb_q[4]), 1);
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h7;
    @(negedge clk); wb_valid = 1'b0; #1;
    chk("sb4_cleared", dut.sb_q, 0);

    // Flush while issuing
    @(negedge clk); if_valid = 1'b1; if_instr = 32'h00100293; if_pc = 32'h300; ex_ready = 1'b0;
    @(negedge clk); if_valid = 1'b0;
    @(negedge clk); #1;
    chk("fl_pre_valid", 32'(ex_valid), 1);
    flush = 1'b1; #1;
    chk("fl_if_ready", 32'(if_ready), 0);
    @(negedge clk); flush = 1'b0; #1;
    chk("fl_ex_valid", 32'(ex_valid), 0);
    chk("fl_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("fl_sb", dut.sb_q, 0);
    chk("fl_if_ready_after", 32'(if_ready), 1);

    // Reset pulse while an instruction waits
    @(negedge clk); if_valid = 1'b1; if_instr = 32'h00138313; if_pc = 32'h340;
    @(negedge clk); if_valid = 1'b0; #1;
    chk("rw_ad1", 32'(rf_ad1), 7);
    rst_n = 1'b0; #1;
    chk("rw_if_ready", 32'(if_ready), 0);
    chk("rw_ex_valid", 32'(ex_valid), 0);
    chk("rw_rf_ad", {rf_ad1, rf_ad2}, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rw_release_ready", 32'(if_ready), 1);
    @(negedge clk); #1;
    chk("rw_discarded", 32'(ex_valid), 0);

    // Random traffic: registers x0..x7 so hazards are frequent
    pend = '0; exp_vld = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if_valid = (c < 2600) && ($urandom % 10 < 6);
      w = $urandom;
      w[6:0] = oplist[$urandom % 9][6:0];
      w[11:7] = 5'($urandom % 8); w[19:15] = 5'($urandom % 8); w[24:20] = 5'($urandom % 8);
      if_instr = w; if_pc = $urandom & ~32'h3;
      ex_ready = (c >= 2600) || ($urandom % 10 < 7);
      nrd = 0;
      for (int r = 1; r < 8; r++) if (pend[r]) begin cand[nrd] = 5'(r); nrd++; end
      wb_valid = (nrd > 0) && ($urandom % 2 == 0);
      wb_rd = (nrd > 0) ? cand[$urandom % nrd] : 5'd0;
      wb_data = $urandom;
      #1;
      chk("rnd_ex_valid", 32'(ex_valid), 32'(exp_vld));
      if (q_instr.size() == 0) chk("rnd_free_ready", 32'(if_ready), 1);
      else if (!ex_valid) chk("rnd_busy_ready", 32'(if_ready), 0);
      fired = ex_valid && ex_ready;
      acc = if_valid && if_ready;
      if (fired) begin
        if (q_instr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rnd_unexpected_issue: got issue of %h, required none", ex_instr);
        end else begin
          w = q_instr.pop_front(); p = q_pc.pop_front();
          chk("rnd_instr", ex_instr, w);
          chk("rnd_pc", ex_pc, p);
          chk("rnd_imm", ex_imm, ref_imm(w));
          chk("rnd_rs1", ex_rs1, rf[w[19:15]]);
          chk("rnd_rs2", ex_rs2, uses_rs2(w) ? rf[w[24:20]] : 32'h0);
          chk("rnd_no_hazard", 32'(blocked(w, pend)), 0);
        end
      end
      if (wb_valid) pend[wb_rd] = 1'b0;
      if (fired && writes_rd(w)) pend[w[11:7]] = 1'b1;
      if (fired) exp_vld = 1'b0;
      if (acc) begin
        q_instr.push_back(if_instr); q_pc.push_back(if_pc); exp_vld = 1'b0;
      end else if (q_instr.size() != 0 && !exp_vld) begin
        exp_vld = !blocked(q_instr[0], pend);
      end
    end
    chk("rnd_drained", 32'(q_instr.size()), 0);
    chk("rnd_sb_clear", dut.sb_q, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 SHALL have parameter: BITS, 32, datapath width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
 clk  in  1  single clock, all state on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 if_valid  in  1  fetch offers instruction
 if_ready  out  1  stage accepts instruction
 if_instr  in  32  RV32I instruction word
 if_pc  in  BITS  instruction address
 rf_ad1  out  5  register-file read address 1 (instr[19:15])
 rf_ad2  out  5  register-file read address 2 (instr[24:20])
 rf_rs1  in  BITS  register-file read data 1 (valid one cycle after address)
 rf_rs2  in  BITS  register-file read data 2
 ex_valid  out  1  issue to execute
 ex_ready  in  1  execute accepts
 ex_pc, ex_rs1, ex_rs2, ex_imm  out  BITS  operands and sign-extended immediate
 ex_instr  out  32  issued instruction word
 wb_valid  in  1  writeback retiring
 wb_rd  in  5  writeback destination
 flush  in  1  synchronous pipeline kill

Function
REQ-003 SHALL implement FSM IDLE/WAIT/ISSUE holding one instruction slot (instr, pc).
REQ-004 SHALL drive if_ready = (IDLE or (ISSUE and ex_ready)) and not flush.
REQ-005 SHALL, on if_valid and if_ready, latch if_instr/if_pc into slot and go to WAIT.
REQ-006 SHALL drive rf_ad1/rf_ad2 from the slot fields in WAIT and ISSUE, 0 in IDLE; register-file read data therefore reflects the slot one cycle later.
REQ-007 SHALL decode: rs1 used except LUI/AUIPC/JAL; rs2 used only for OP/STORE/BRANCH; rd written except STORE/BRANCH; x0 never counts as used or written.
REQ-008 SHALL keep a 32-bit scoreboard of pending destination registers; bit 0 constant 0.
REQ-009 SHALL, in WAIT, stall while any used source or the written rd has its scoreboard bit set, except that a bit being cleared by wb_valid/wb_rd this cycle counts as clear (register-file write is visible to the same-edge read).
REQ-010 SHALL move WAIT->ISSUE on the edge where no hazard holds; minimum latency accept-to-ex_valid is 2 cycles.
REQ-011 SHALL, in ISSUE, assert ex_valid with ex_rs1=rf_rs1, ex_rs2=rf_rs2 (rs2 forced 0 when unused), ex_pc/ex_instr from slot, ex_imm per I/S/B/U/J format; outputs stable while ex_ready low.
REQ-012 SHALL, on ex_valid and ex_ready, set scoreboard[rd] if rd written, then go to WAIT (new instruction accepted same edge) or IDLE.
REQ-013 SHALL clear scoreboard[wb_rd] on wb_valid (wb_rd=0 ignored); simultaneous set and clear of same bit: set wins.
REQ-014 SHALL, on flush, go to IDLE and drop the slot, overriding all handshakes; scoreboard unaffected.
REQ-015 SHALL sustain one issue per 2 cycles with no hazards and ex_ready high.

Reset
REQ-016 SHALL, while rst_n low, force state IDLE, slot 0, scoreboard 0, ex_valid 0, if_ready 0, rf_ad1/rf_ad2 0; all ex_* data 0.
REQ-017 SHALL assert if_ready in the first cycle after rst_n deasserts; reset mid-ISSUE discards the instruction without scoreboard update.

Structure
REQ-018 SHALL place opcode constants, immediate-format enum and FSM state encoding in shared package riscv_pkg.
REQ-019 SHALL implement immediate extraction as sub-module imm_gen (combinational, instr in, BITS imm out).

Verification
REQ-020 ADDI x1,x0,5 (0x00500093) accepted cycle 0, ex_ready=1 -> ex_valid cycle 2, ex_imm=5, rf_ad1=0, scoreboard[1]=1 after cycle 2.
REQ-021 ADD x2,x1,x1 following with x1 pending -> ex_valid held 0; wb_valid=1,wb_rd=1 in cycle N -> ex_valid in cycle N+1 with ex_rs1=ex_rs2=written value.
REQ-022 SW x3,8(x0) with ex_ready=0 for 3 cycles -> ex_valid and all ex_* stable 3 cycles, if_ready=0; scoreboard unchanged after issue.
REQ-023 Issue of rd=4 and wb_valid with wb_rd=4 on same edge -> scoreboard[4]=1 afterward.
REQ-024 flush while in ISSUE -> ex_valid=0 next cycle, state IDLE, scoreboard unchanged; rst_n pulse low mid-WAIT -> all outputs 0 immediately, if_ready=1 after release.
